ins_fpu_arbiter: RTL and testbench
==================================

# ins_fpu_arbiter

Shares one external pipelined single-precision floating-point unit between the INS attitude sub-blocks (accelerometer, magnetometer, gyro, quaternion, matrix and Euler stages). Requesters post one operation each and receive the result on a tagged return path. Grants are round-robin with one outstanding operation per requester. The FPU returns results in issue order, and an internal tag FIFO routes each result back to its owner.

## Interface
- N, default 4: number of requesters (2..8).
- DEPTH, default 8: tag FIFO depth, i.e. the maximum number of operations in flight inside the FPU (power of 2).
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  N  request bit per requester; held high with operands stable until the matching gnt pulse.
- op_flat  in  2N  opcode per requester, bits [2i+1:2i]: 00 add, 01 sub, 10 mul, 11 div.
- a_flat  in  32N  operand A per requester, bits [32i+31:32i], IEEE-754 single.
- b_flat  in  32N  operand B per requester, same packing.
- gnt  out  N  one-cycle grant pulse; operands were captured at the preceding edge.
- done  out  N  one-cycle result-valid pulse, at most one bit set.
- result  out  32  result for the requester whose done bit is set; holds its last value otherwise.
- busy  out  1  high while the tag FIFO is non-empty.
- err  out  1  sticky; set when fpu_rdy arrives with the tag FIFO empty. Cleared only by rst.
- fpu_nd  out  1  new-data strobe to the FPU, one cycle per issued operation.
- fpu_op  out  2  opcode to the FPU.
- fpu_a, fpu_b  out  32 each  operands to the FPU.
- fpu_rdy  in  1  FPU result-valid strobe; results arrive in issue order.
- fpu_result  in  32  FPU result.

## Operation
- Eligibility: requester i is eligible when req[i]=1, pending[i]=0 and gnt[i]=0 in the current cycle.
- Issue condition: at least one requester is eligible and the FIFO count is less than DEPTH.
- Arbitration is round-robin.
  - The search starts at the requester after the last granted one.
  - After reset the pointer is N-1, so requester 0 has highest priority.
- At the issue edge:
  - gnt[w], fpu_nd, fpu_op, fpu_a and fpu_b are registered from winner w.
  - pending[w] is set.
  - w is pushed into the tag FIFO.
  - The pointer is set to w.
- When no operation issues, fpu_nd=0 and gnt=0; fpu_op, fpu_a and fpu_b hold their previous values.
- Return: on fpu_rdy=1 with the FIFO non-empty:
  - pop tag t;
  - register done[t]=1 and result=fpu_result;
  - clear pending[t].
- On fpu_rdy=1 with the FIFO empty: set err, drop the result, leave done at 0.
- Push and pop in the same cycle leave the count unchanged; both take effect.
- Issue is not allowed when count==DEPTH, even if a pop occurs that cycle. There is no full-bypass path.
- A requester whose pending bit clears at the done edge may be granted again at the following edge at the earliest.
- Requester protocol:
  - deassert req in the gnt cycle, or keep it high to queue the next operation;
  - a held req is eligible again only after its done pulse.
- Count width is log2(DEPTH)+1. Read and write pointers are log2(DEPTH) bits and wrap naturally.
- Reset values: gnt=0, done=0, result=0, busy=0, err=0, fpu_nd=0, fpu_op=0, fpu_a=0, fpu_b=0, pending=0, count=0, pointer=N-1.
- Reset mid-operation discards all in-flight tags. The FPU must share rst; otherwise late fpu_rdy pulses set err.

## Timing
- Issue latency: req sampled high at edge k with issue allowed -> gnt and fpu_nd high during cycle k+1.
- Return latency: fpu_rdy high at edge m -> done and result valid during cycle m+1.
- Throughput: one issue per cycle across different requesters, until DEPTH operations are in flight.
- Per requester: at most one operation outstanding. Minimum re-issue gap is 2 cycles after its done pulse.
- busy rises the cycle after the first issue and falls the cycle after the pop that empties the FIFO.

## Test plan
- Single request:
  - stimulus: requester 2 requests mul, a=0x40000000, b=0x40400000; FPU model has 4-cycle latency;
  - required: gnt[2] one cycle later; fpu_op=10; done[2] 5 cycles after gnt with result=0x40C00000; busy high throughout.
- Round-robin fairness: all N requesters hold req continuously.
  - Required grant order after reset: 0,1,2,3, each granted once.
  - No requester is regranted before its done pulse.
- Full FIFO: set DEPTH=2 with a stalled FPU model (fpu_rdy held low).
  - Required: exactly 2 grants; remaining requesters wait.
  - One fpu_rdy -> a further grant no earlier than the cycle after done.
- Simultaneous push and pop: fpu_rdy coincides with a new issue.
  - Required: count unchanged; result routed to the oldest tag; the new tag is routed on the next fpu_rdy.
- Error and reset:
  - fpu_rdy with the FIFO empty -> err=1 sticky, done stays 0;
  - rst asserted mid-flight -> all outputs take reset values on the same edge, err clears, and the pointer favours requester 0.

Source files
------------

// File: rtl/ins_fpu_arbiter_if.sv
// Requester-side and FPU-side signals of the shared-FPU arbiter.
// Handshake: req[i] stays high with operands stable until gnt[i] pulses; done[i] pulses once per result.
interface ins_fpu_arbiter_if #(
  parameter int N = 4
);
  logic [N-1:0]    req;
  logic [2*N-1:0]  op_flat;
  logic [32*N-1:0] a_flat;
  logic [32*N-1:0] b_flat;
  logic [N-1:0]    gnt;
  logic [N-1:0]    done;
  logic [31:0]     result;
  logic            busy;
  logic            err;
  logic            fpu_nd;
  logic [1:0]      fpu_op;
  logic [31:0]     fpu_a;
  logic [31:0]     fpu_b;
  logic            fpu_rdy;
  logic [31:0]     fpu_result;

  modport master (
    output req, op_flat, a_flat, b_flat, fpu_rdy, fpu_result,
    input  gnt, done, result, busy, err, fpu_nd, fpu_op, fpu_a, fpu_b
  );

  modport slave (
    input  req, op_flat, a_flat, b_flat, fpu_rdy, fpu_result,
    output gnt, done, result, busy, err, fpu_nd, fpu_op, fpu_a, fpu_b
  );
endinterface

// File: rtl/ins_fpu_arbiter.sv
// Round-robin arbiter sharing one in-order pipelined FPU among N requesters;
// a tag FIFO records the issuing requester so each result returns to its owner.
module ins_fpu_arbiter #(
  parameter int N     = 4,
  parameter int DEPTH = 8
) (
  input logic               clk,
  input logic               rst,
  ins_fpu_arbiter_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(N);

  logic [N-1:0]  gnt_q;
  logic [N-1:0]  done_q;
  logic [31:0]   result_q;
  logic          err_q;
  logic          nd_q;
  logic [1:0]    op_q;
  logic [31:0]   a_q;
  logic [31:0]   b_q;

  logic [N-1:0]  pending;
  logic [TW-1:0] rr_ptr;
  logic [TW-1:0] tag_mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic [N-1:0]  elig;
  logic          found;
  logic [TW-1:0] win;
  logic [N-1:0]  win_oh;
  logic [TW-1:0] pop_tag;
  logic [N-1:0]  pop_oh;
  logic          issue;
  logic          pop;

  // Two passes give round-robin order: first the indices above the last
  // winner, then wrap around to the ones at or below it.
  always_comb begin
    elig  = bus.req & ~pending & ~gnt_q;
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < N; i++) begin
      if (!found && elig[i] && (i > int'(rr_ptr))) begin
        found = 1'b1;
        win   = TW'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && elig[i] && (i <= int'(rr_ptr))) begin
        found = 1'b1;
        win   = TW'(i);
      end
    end
  end

  // A pop in the same cycle does not free a slot for issue: no full bypass.
  assign issue   = found && (count != CW'(DEPTH));
  assign pop     = bus.fpu_rdy && (count != '0);
  assign pop_tag = tag_mem[rd_ptr];
  assign win_oh  = N'(1) << win;
  assign pop_oh  = N'(1) << pop_tag;

  always_ff @(posedge clk) begin
    if (issue) begin
      tag_mem[wr_ptr] <= win;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_q    <= '0;
      done_q   <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      nd_q     <= 1'b0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      pending  <= '0;
      rr_ptr   <= TW'(N - 1);
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      gnt_q <= issue ? win_oh : '0;
      nd_q  <= issue;
      if (issue) begin
        op_q   <= bus.op_flat[2*win +: 2];
        a_q    <= bus.a_flat[32*win +: 32];
        b_q    <= bus.b_flat[32*win +: 32];
        rr_ptr <= win;
        wr_ptr <= wr_ptr + 1'b1;
      end

      done_q <= pop ? pop_oh : '0;
      if (pop) begin
        result_q <= bus.fpu_result;
        rd_ptr   <= rd_ptr + 1'b1;
      end

      // A result with no owner means the FPU and arbiter are out of step.
      if (bus.fpu_rdy && (count == '0)) begin
        err_q <= 1'b1;
      end

      pending <= (pending | (issue ? win_oh : '0)) & ~(pop ? pop_oh : '0);
      count   <= count + CW'(issue) - CW'(pop);
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.busy   = (count != '0);
  assign bus.err    = err_q;
  assign bus.fpu_nd = nd_q;
  assign bus.fpu_op = op_q;
  assign bus.fpu_a  = a_q;
  assign bus.fpu_b  = b_q;
endmodule

// File: tb/tb_ins_fpu_arbiter.sv
// Bench for ins_fpu_arbiter: DEPTH=8 instance with a 4-cycle FPU model,
// plus a DEPTH=2 instance with a hand-driven, stalled FPU.
module tb_ins_fpu_arbiter;
  localparam int N   = 4;
  localparam int W   = 36;
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ins_fpu_arbiter_if #(.N(N)) bus1 ();
  ins_fpu_arbiter_if #(.N(N)) bus2 ();

  ins_fpu_arbiter #(.N(N), .DEPTH(8)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
  ins_fpu_arbiter #(.N(N), .DEPTH(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp_q[$];
  int           grant_log[$];
  logic [N-1:0] outstanding;
  logic [1:0]   s_op [N];
  logic [31:0]  s_a  [N];
  logic [31:0]  s_b  [N];

  // Stand-in for the FPU datapath: exact for the directed 2.0*3.0 case,
  // otherwise a fixed scramble of the operands that still depends on all of them.
  function automatic logic [31:0] fpu_fn(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    if (op == 2'b10 && a == 32'h4000_0000 && b == 32'h4040_0000) return 32'h40C0_0000;
    return {op, 30'h0} ^ a ^ {b[15:0], b[31:16]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // ---------------- FPU model for dut1 ----------------
  logic [LAT-1:0] pv;
  logic [31:0]    pr [LAT];
  logic           man_rdy;
  logic [31:0]    man_res;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pv <= '0;
      for (int k = 0; k < LAT; k++) pr[k] <= '0;
    end else begin
      pv    <= {pv[LAT-2:0], bus1.fpu_nd};
      pr[0] <= fpu_fn(bus1.fpu_op, bus1.fpu_a, bus1.fpu_b);
      for (int k = 1; k < LAT; k++) pr[k] <= pr[k-1];
    end
  end

  assign bus1.fpu_rdy    = pv[LAT-1] | man_rdy;
  assign bus1.fpu_result = man_rdy ? man_res : pr[LAT-1];

  // ---------------- scoreboard / monitor for dut1 ----------------
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      grant_log.delete();
      outstanding = '0;
    end else begin
      check("nd_matches_gnt", bus1.fpu_nd, (bus1.gnt != '0));
      if (bus1.gnt != '0) begin
        int g;
        g = 0;
        for (int i = 0; i < N; i++) if (bus1.gnt[i]) g = i;
        check("gnt_onehot", $countones(bus1.gnt), 1);
        check("issue_op", bus1.fpu_op, s_op[g]);
        check("issue_a", bus1.fpu_a, s_a[g]);
        check("issue_b", bus1.fpu_b, s_b[g]);
        check("regrant_before_done", outstanding[g], 1'b0);
        outstanding[g] = 1'b1;
        exp_q.push_back({4'(g), fpu_fn(s_op[g], s_a[g], s_b[g])});
        grant_log.push_back(g);
      end
      if (bus1.done != '0) begin
        if (exp_q.size() == 0) begin
          check("done_unexpected", bus1.done, 0);
        end else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          check("done_tag", bus1.done, N'(1) << e[35:32]);
          check("done_result", bus1.result, e[31:0]);
          outstanding[e[35:32]] = 1'b0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b);
    s_op[i] = op;
    s_a[i]  = a;
    s_b[i]  = b;
    bus1.op_flat[2*i +: 2]  = op;
    bus1.a_flat[32*i +: 32] = a;
    bus1.b_flat[32*i +: 32] = b;
    bus1.req[i] = 1'b1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    bus1.req = '0;
    bus2.req = '0;
    man_rdy  = 1'b0;
    bus2.fpu_rdy = 1'b0;
    @(negedge clk);
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((bus1.busy || exp_q.size() != 0) && n < 200) begin
      tick();
      n++;
    end
    check(tag, (n < 200), 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    bus1.req = '0; bus1.op_flat = '0; bus1.a_flat = '0; bus1.b_flat = '0;
    bus2.req = '0; bus2.op_flat = '0; bus2.a_flat = '0; bus2.b_flat = '0;
    bus2.fpu_rdy = 1'b0; bus2.fpu_result = '0;
    man_rdy = 1'b0; man_res = '0;
    for (int i = 0; i < N; i++) begin
      s_op[i] = '0; s_a[i] = '0; s_b[i] = '0;
    end

    rst = 1'b1;
    #2;
    check("rst_gnt", bus1.gnt, 0);
    check("rst_done", bus1.done, 0);
    check("rst_result", bus1.result, 0);
    check("rst_busy", bus1.busy, 0);
    check("rst_err", bus1.err, 0);
    check("rst_nd", bus1.fpu_nd, 0);
    check("rst_op", bus1.fpu_op, 0);
    check("rst_a", bus1.fpu_a, 0);
    check("rst_b", bus1.fpu_b, 0);
    do_reset();

    // single request: requester 2, 2.0 * 3.0
    set_req(2, 2'b10, 32'h4000_0000, 32'h4040_0000);
    tick();
    check("single_gnt", bus1.gnt, 4'b0100);
    check("single_nd", bus1.fpu_nd, 1);
    check("single_op", bus1.fpu_op, 2'b10);
    check("single_busy", bus1.busy, 1);
    bus1.req[2] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("single_done_early", bus1.done, 0);
      check("single_busy_held", bus1.busy, 1);
    end
    tick();
    check("single_done", bus1.done, 4'b0100);
    check("single_result", bus1.result, 32'h40C0_0000);
    check("single_busy_fall", bus1.busy, 0);
    tick();
    check("done_pulse_width", bus1.done, 0);
    check("result_hold", bus1.result, 32'h40C0_0000);

    // push and pop on the same edge
    set_req(1, 2'b00, 32'h3F80_0000, 32'h4000_0000);
    tick();
    check("pp_first_gnt", bus1.gnt, 4'b0010);
    bus1.req[1] = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    set_req(3, 2'b11, 32'h4100_0000, 32'h4080_0000);
    tick();
    check("pp_second_gnt", bus1.gnt, 4'b1000);
    check("pp_first_done", bus1.done, 4'b0010);
    check("pp_busy", bus1.busy, 1);
    bus1.req[3] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("pp_second_early", bus1.done, 0);
    end
    tick();
    check("pp_second_done", bus1.done, 4'b1000);
    check("pp_count_restored", bus1.busy, 0);

    // round-robin fairness with all requesters held high
    do_reset();
    for (int i = 0; i < N; i++)
      set_req(i, 2'(i), 32'h3F80_0000 + 32'(i), 32'h4000_0000 + 32'(i << 4));
    repeat (30) tick();
    n = 0;
    bus1.req = bus1.req & ~bus1.gnt;
    while (bus1.req != '0 && n < 50) begin
      tick();
      bus1.req = bus1.req & ~bus1.gnt;
      n++;
    end
    check("rr_release_timeout", (n < 50), 1'b1);
    wait_idle("rr_drain_timeout");
    check("rr_grant_count", (grant_log.size() >= 8), 1'b1);
    for (int i = 0; i < 8; i++)
      if (grant_log.size() > i) check("rr_order", grant_log[i], i % 4);

    // result with an empty FIFO
    man_res = 32'hDEAD_BEEF;
    man_rdy = 1'b1;
    tick();
    man_rdy = 1'b0;
    check("err_set", bus1.err, 1);
    check("err_no_done", bus1.done, 0);
    tick();
    tick();
    check("err_sticky", bus1.err, 1);

    // reset in the middle of traffic
    for (int i = 0; i < N; i++)
      set_req(i, 2'(3 - i), 32'h4200_0000 + 32'(i), 32'h3F00_0000 + 32'(i));
    tick();
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_gnt", bus1.gnt, 0);
    check("mid_rst_done", bus1.done, 0);
    check("mid_rst_result", bus1.result, 0);
    check("mid_rst_busy", bus1.busy, 0);
    check("mid_rst_err", bus1.err, 0);
    check("mid_rst_nd", bus1.fpu_nd, 0);
    check("mid_rst_op", bus1.fpu_op, 0);
    check("mid_rst_a", bus1.fpu_a, 0);
    bus1.req = '0;
    @(negedge clk);
    tick();
    rst = 1'b0;
    set_req(3, 2'b01, 32'h4040_0000, 32'h3F80_0000);
    set_req(0, 2'b10, 32'h4080_0000, 32'h4000_0000);
    tick();
    check("post_rst_first", bus1.gnt, 4'b0001);
    bus1.req[0] = 1'b0;
    tick();
    check("post_rst_second", bus1.gnt, 4'b1000);
    bus1.req[3] = 1'b0;
    wait_idle("post_rst_drain_timeout");

    // DEPTH=2 instance with a stalled FPU
    do_reset();
    for (int i = 0; i < N; i++) begin
      bus2.op_flat[2*i +: 2]  = 2'(i);
      bus2.a_flat[32*i +: 32] = 32'h0000_1000 + 32'(i);
      bus2.b_flat[32*i +: 32] = 32'h0000_2000 + 32'(i);
    end
    bus2.req = '1;
    tick();
    check("ff_gnt0", bus2.gnt, 4'b0001);
    check("ff_op0", bus2.fpu_op, 2'b00);
    check("ff_a0", bus2.fpu_a, 32'h0000_1000);
    bus2.req[0] = 1'b0;
    tick();
    check("ff_gnt1", bus2.gnt, 4'b0010);
    check("ff_b1", bus2.fpu_b, 32'h0000_2001);
    bus2.req[1] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("ff_blocked", bus2.gnt, 0);
      check("ff_busy", bus2.busy, 1);
    end
    bus2.fpu_result = 32'h1234_5678;
    bus2.fpu_rdy    = 1'b1;
    tick();
    bus2.fpu_rdy = 1'b0;
    check("ff_done0", bus2.done, 4'b0001);
    check("ff_result0", bus2.result, 32'h1234_5678);
    check("ff_no_bypass", bus2.gnt, 0);
    tick();
    check("ff_regrant", bus2.gnt, 4'b0100);
    check("ff_regrant_op", bus2.fpu_op, 2'b10);
    bus2.req[2] = 1'b0;
    tick();
    check("ff_full_again", bus2.gnt, 0);
    bus2.fpu_result = 32'h9ABC_DEF0;
    bus2.fpu_rdy    = 1'b1;
    tick();
    bus2.fpu_rdy = 1'b0;
    check("ff_done1", bus2.done, 4'b0010);
    check("ff_result1", bus2.result, 32'h9ABC_DEF0);
    tick();
    check("ff_last_gnt", bus2.gnt, 4'b1000);
    bus2.req[3] = 1'b0;
    check("ff_no_err", bus2.err, 0);
    do_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
